// File: rtl/adder_tree_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_tree_pkg
// Description : Shared command codes, controller state encoding and result
//               sizing helpers for the adder tree sequencer.
// Contents    : CMD_LOAD_A / CMD_LOAD_B / CMD_COMPUTE command bytes,
//               state_t controller states, res_width() / res_bytes().
// Revision    : 1.0 - initial release
// ============================================================================
package adder_tree_pkg;

    localparam logic [7:0] CMD_LOAD_A  = 8'h01;
    localparam logic [7:0] CMD_LOAD_B  = 8'h02;
    localparam logic [7:0] CMD_COMPUTE = 8'h03;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        SETTLE = 3'd3,
        SEND   = 3'd4
    } state_t;

    // Width of the tree sum over 2*length elements of width bits, plus one
    // bit of headroom.
    function automatic int res_width(input int width, input int length);
        return $clog2(length * 2) + width + 1;
    endfunction

    // Number of bytes needed to return a res_width() result.
    function automatic int res_bytes(input int width, input int length);
        return (res_width(width, length) + 7) / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : result_serializer
// Description : Holds the captured tree result and returns it LSB-first over
//               a valid/ready byte interface.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               capture, result   - load strobe and value to hold
//               tx_data/valid/ready - outgoing byte stream
//               done              - pulse on the transfer of the last byte
// Revision    : 1.0 - initial release
// ============================================================================
module result_serializer #(
    parameter int RES_W  = 12,
    parameter int NBYTES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic [RES_W-1:0] result,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             done
);

    localparam int KW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int EXT_W = NBYTES * 8;

    logic [RES_W-1:0] res_q, res_d;
    logic [KW-1:0]    k_q, k_d;
    logic             tx_valid_q, tx_valid_d;

    logic             w_beat;
    logic             w_last;
    logic [EXT_W-1:0] w_res_ext;
    logic [7:0]       w_tx_byte;

    assign w_beat    = tx_valid_q && tx_ready;
    assign w_last    = (k_q == KW'(NBYTES - 1));
    assign done      = w_beat && w_last;
    // Zero-extend so the top byte reads 0 above RES_W.
    assign w_res_ext = EXT_W'(res_q);

    always_comb begin
        w_tx_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (k_q == KW'(i)) begin
                w_tx_byte = w_res_ext[8*i +: 8];
            end
        end
    end

    assign tx_data  = w_tx_byte;
    assign tx_valid = tx_valid_q;

    always_comb begin
        res_d      = res_q;
        k_d        = k_q;
        tx_valid_d = tx_valid_q;
        if (capture) begin
            res_d      = result;
            k_d        = '0;
            tx_valid_d = 1'b1;
        end else if (w_beat) begin
            if (w_last) begin
                k_d        = '0;
                tx_valid_d = 1'b0;
            end else begin
                k_d = k_q + KW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q      <= '0;
            k_q        <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            res_q      <= res_d;
            k_q        <= k_d;
            tx_valid_q <= tx_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_tree_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adder_tree_ctrl
// Description : Byte-stream sequencer for the combinational array adder tree.
//               Loads operand arrays A/B from an rx byte stream, triggers a
//               compute, waits a settle time, captures the tree output and
//               returns it LSB-first on a tx byte stream.
// Ports       : clk, rst                 - clock, async active-high reset
//               rx_data/valid/ready      - command and operand bytes in
//               tx_data/valid/ready      - result bytes out
//               array_a, array_b         - operand arrays to the tree
//               tree_result              - tree output
//               busy                     - high whenever not IDLE
//               cmd_err                  - one-cycle pulse on unknown command
// Revision    : 1.0 - initial release
// ============================================================================
module adder_tree_ctrl
    import adder_tree_pkg::*;
#(
    parameter  int WIDTH         = 8,
    parameter  int LENGTH        = 512,
    parameter  int SETTLE_CYCLES = 2,
    localparam int RES_W         = res_width(WIDTH, LENGTH),
    localparam int NBYTES        = res_bytes(WIDTH, LENGTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [WIDTH-1:0] array_a [LENGTH-1:0],
    output logic [WIDTH-1:0] array_b [LENGTH-1:0],
    input  logic [RES_W-1:0] tree_result,
    output logic             busy,
    output logic             cmd_err
);

    localparam int IDX_W = $clog2(LENGTH);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] array_a_q [LENGTH-1:0];
    logic [WIDTH-1:0] array_a_d [LENGTH-1:0];
    logic [WIDTH-1:0] array_b_q [LENGTH-1:0];
    logic [WIDTH-1:0] array_b_d [LENGTH-1:0];
    logic             rx_ready_q, rx_ready_d;
    logic             busy_q, busy_d;
    logic             cmd_err_q, cmd_err_d;

    logic             w_rx_beat;
    logic             w_idx_last;
    logic             w_capture;
    logic             w_done;

    assign w_rx_beat  = rx_valid && rx_ready_q;
    assign w_idx_last = (idx_q == IDX_W'(LENGTH - 1));
    // Capture happens in the cycle the settle counter reaches its last value,
    // so the result register and tx_valid both load on that edge.
    assign w_capture  = (state_q == SETTLE) && (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        array_a_d = array_a_q;
        array_b_d = array_b_q;
        cmd_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_rx_beat) begin
                    case (rx_data)
                        CMD_LOAD_A:  state_d = LOAD_A;
                        CMD_LOAD_B:  state_d = LOAD_B;
                        CMD_COMPUTE: begin
                            state_d = SETTLE;
                            cnt_d   = '0;
                        end
                        default:     cmd_err_d = 1'b1;
                    endcase
                end
            end
            LOAD_A: begin
                if (w_rx_beat) begin
                    array_a_d[idx_q] = rx_data[WIDTH-1:0];
                    if (w_idx_last) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            LOAD_B: begin
                if (w_rx_beat) begin
                    array_b_d[idx_q] = rx_data[WIDTH-1:0];
                    if (w_idx_last) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            SETTLE: begin
                if (w_capture) begin
                    state_d = SEND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SEND: begin
                if (w_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        rx_ready_d = (state_d == IDLE) || (state_d == LOAD_A) || (state_d == LOAD_B);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            array_a_q  <= '{default: '0};
            array_b_q  <= '{default: '0};
            rx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            array_a_q  <= array_a_d;
            array_b_q  <= array_b_d;
            rx_ready_q <= rx_ready_d;
            busy_q     <= busy_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    result_serializer #(
        .RES_W  (RES_W),
        .NBYTES (NBYTES)
    ) u_serializer (
        .clk      (clk),
        .rst      (rst),
        .capture  (w_capture),
        .result   (tree_result),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .done     (w_done)
    );

    assign array_a  = array_a_q;
    assign array_b  = array_b_q;
    assign rx_ready = rx_ready_q;
    assign busy     = busy_q;
    assign cmd_err  = cmd_err_q;

endmodule
`default_nettype wire
